// File: rtl/register_deserializer_sipo.sv
// -----------------------------------------------------------------------------
// register_deserializer_sipo
//   Serial-in, parallel-out deserializer. Assembles a bit stream into WIDTH-bit
//   words and presents each word through a one-entry valid/ready buffer that
//   feeds the downstream PIPO storage register. A two-state controller
//   (COLLECT / HOLD) back-pressures the serial source while a finished word
//   waits for the buffer to drain.
//
// Optional feature macro: DESER_PARITY_EN
//   defined   : each frame is WIDTH data bits plus one even-parity bit;
//               parity_err is registered alongside the word.
//   undefined : frame is WIDTH bits, parity_err is tied to 0.
//
// Ports
//   clk           in   clock, all state changes on posedge
//   clear_n       in   synchronous active-low reset
//   serial_in     in   serial data bit
//   serial_valid  in   serial_in carries a bit this cycle
//   serial_ready  out  block accepts a bit this cycle (decoded from state)
//   parallel_out  out  [WIDTH-1:0] buffered word
//   out_valid     out  parallel_out holds an undelivered word
//   out_ready     in   downstream takes the word this cycle
//   parity_err    out  parity flag of the buffered word
// -----------------------------------------------------------------------------
module register_deserializer_sipo #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             serial_in,
  input  logic             serial_valid,
  output logic             serial_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err
);

`ifdef DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int            CW   = $clog2(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [CW-1:0]      bit_count_r;
  logic [WIDTH-1:0]   shift_r;
  logic [WIDTH-1:0]   shift_next_s;
  logic [WIDTH-1:0]   word_s;
  logic [WIDTH-1:0]   parallel_r;
  logic               out_valid_r;
  logic               accept_s;
  logic               last_s;
  logic               data_bit_s;
  logic               buf_free_s;
  logic               load_new_s;
  logic               load_held_s;

  assign serial_ready = (state_r == ST_COLLECT);
  assign accept_s     = serial_valid && serial_ready;
  assign last_s       = (bit_count_r == LAST);
  assign buf_free_s   = !out_valid_r || out_ready;
  assign parallel_out = parallel_r;
  assign out_valid    = out_valid_r;

  assign shift_next_s = MSB_FIRST ? {shift_r[WIDTH-2:0], serial_in}
                                  : {serial_in, shift_r[WIDTH-1:1]};

`ifdef DESER_PARITY_EN
  // The trailing parity bit is not shifted in, so the word is already complete
  // in shift_r when the last frame bit arrives.
  assign data_bit_s = (bit_count_r != LAST);
  assign word_s     = shift_r;
`else
  // Without parity the last frame bit is a data bit, so the word being loaded
  // is the shift register including this cycle's bit.
  assign data_bit_s = 1'b1;
  assign word_s     = shift_next_s;
`endif

  // State register for the COLLECT/HOLD controller.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_r <= ST_COLLECT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: stall in HOLD when a finished word finds the buffer busy.
  always_comb begin
    state_next_s = state_r;
    load_new_s   = 1'b0;
    load_held_s  = 1'b0;
    case (state_r)
      ST_COLLECT: begin
        if (accept_s && last_s) begin
          if (buf_free_s) begin
            load_new_s   = 1'b1;
            state_next_s = ST_COLLECT;
          end else begin
            state_next_s = ST_HOLD;
          end
        end else begin
          state_next_s = ST_COLLECT;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          load_held_s  = 1'b1;
          state_next_s = ST_COLLECT;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_COLLECT;
      end
    endcase
  end

  // Bit assembly: shift accepted data bits and track position within the frame.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      shift_r     <= {WIDTH{1'b0}};
      bit_count_r <= {CW{1'b0}};
    end else if (accept_s) begin
      bit_count_r <= last_s ? {CW{1'b0}} : bit_count_r + CW'(1'b1);
      if (data_bit_s) begin
        shift_r <= shift_next_s;
      end
    end
  end

  // Output buffer: load a fresh or held word, otherwise drop valid on transfer.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      parallel_r  <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else if (load_new_s) begin
      parallel_r  <= word_s;
      out_valid_r <= 1'b1;
    end else if (load_held_s) begin
      parallel_r  <= shift_r;
      out_valid_r <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef DESER_PARITY_EN
  logic par_bit_r;
  logic parity_err_r;

  // Even parity over data plus parity bit; a nonzero result flags an error.
  function automatic logic frame_parity(input logic [WIDTH-1:0] data,
                                        input logic             pbit);
    return ^{data, pbit};
  endfunction

  // Parity tracking: keep the received parity bit for a held word and
  // register the error flag together with the word it belongs to.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      par_bit_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      if (accept_s && last_s) begin
        par_bit_r <= serial_in;
      end
      if (load_new_s) begin
        parity_err_r <= frame_parity(shift_r, serial_in);
      end else if (load_held_s) begin
        parity_err_r <= frame_parity(shift_r, par_bit_r);
      end
    end
  end

  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_register_deserializer_sipo.sv
// -----------------------------------------------------------------------------
// Testbench for register_deserializer_sipo. Two instances share the stimulus:
// one with MSB_FIRST=1, one with MSB_FIRST=0. A frame-level reference model
// collects received bits in a queue and tracks the output buffer and stall.
// -----------------------------------------------------------------------------
module tb_register_deserializer_sipo;

  localparam int W = 4;
`ifdef DESER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk;
  logic         clear_n;
  logic         serial_in;
  logic         serial_valid;
  logic         out_ready;

  logic         m_sready, l_sready;
  logic [W-1:0] m_pout, l_pout;
  logic         m_ovalid, l_ovalid;
  logic         m_perr, l_perr;

  int total;
  int bad;

  // reference model state
  logic         q[$];
  logic         md_valid;
  logic         md_hold;
  logic [W-1:0] md_buf_m, md_buf_l, md_held_m, md_held_l;
  logic         md_err, md_held_err;

  register_deserializer_sipo #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .clear_n(clear_n), .serial_in(serial_in),
    .serial_valid(serial_valid), .serial_ready(m_sready),
    .parallel_out(m_pout), .out_valid(m_ovalid), .out_ready(out_ready),
    .parity_err(m_perr)
  );

  register_deserializer_sipo #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .clear_n(clear_n), .serial_in(serial_in),
    .serial_valid(serial_valid), .serial_ready(l_sready),
    .parallel_out(l_pout), .out_valid(l_ovalid), .out_ready(out_ready),
    .parity_err(l_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle, advance the reference model at the edge, return at negedge.
  task automatic step(input logic sv, input logic si, input logic ordy,
                      input logic cn);
    logic [W-1:0] wm, wl;
    logic         e;
    logic         done;
    logic         xfer;
    serial_valid = sv;
    serial_in    = si;
    out_ready    = ordy;
    clear_n      = cn;
    @(posedge clk);
    wm = '0; wl = '0; e = 1'b0; done = 1'b0;
    if (!cn) begin
      q.delete();
      md_valid = 1'b0; md_hold = 1'b0;
      md_buf_m = '0; md_buf_l = '0; md_err = 1'b0;
    end else if (md_hold) begin
      if (ordy) begin
        md_buf_m = md_held_m; md_buf_l = md_held_l; md_err = md_held_err;
        md_hold  = 1'b0;
      end
    end else begin
      xfer = md_valid && ordy;
      if (sv) begin
        q.push_back(si);
        if (q.size() == FRAME) begin
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = q[i];
            wl[i]     = q[i];
          end
`ifdef DESER_PARITY_EN
          foreach (q[i]) e = e ^ q[i];
`endif
          q.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!md_valid || ordy) begin
          md_buf_m = wm; md_buf_l = wl; md_err = e; md_valid = 1'b1;
        end else begin
          md_held_m = wm; md_held_l = wl; md_held_err = e; md_hold = 1'b1;
        end
      end else if (xfer) begin
        md_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Send one frame in stream order d[3], d[2], d[1], d[0] (+ parity bit).
  task automatic send_frame(input logic [W-1:0] d, input logic ordy,
                            input logic pbit);
    for (int i = W - 1; i >= 0; i--) step(1'b1, d[i], ordy, 1'b1);
`ifdef DESER_PARITY_EN
    step(1'b1, pbit, ordy, 1'b1);
`else
    if (pbit === 1'bz) step(1'b0, 1'b0, ordy, 1'b1);
`endif
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (m_ovalid !== 1'b0 || l_ovalid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b/%b exp=0", m_ovalid, l_ovalid);
    end
    total++;
    if (m_pout !== 4'b0000 || l_pout !== 4'b0000) begin
      bad++; $display("FAIL reset_word got=%b/%b exp=0000", m_pout, l_pout);
    end
    total++;
    if (m_sready !== 1'b1 || l_sready !== 1'b1) begin
      bad++; $display("FAIL reset_sready got=%b/%b exp=1", m_sready, l_sready);
    end
    total++;
    if (m_perr !== 1'b0) begin
      bad++; $display("FAIL reset_perr got=%b exp=0", m_perr);
    end
  endtask

  task automatic test_bit_order();
    send_frame(4'b1101, 1'b1, 1'b1);
    total++;
    if (m_pout !== 4'b1101 || m_ovalid !== 1'b1) begin
      bad++; $display("FAIL msb_first got=%b v=%b exp=1101 v=1", m_pout, m_ovalid);
    end
    total++;
    if (l_pout !== 4'b1011 || l_ovalid !== 1'b1) begin
      bad++; $display("FAIL lsb_first got=%b v=%b exp=1011 v=1", l_pout, l_ovalid);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (m_ovalid !== 1'b0 || l_ovalid !== 1'b0) begin
      bad++; $display("FAIL one_cycle_valid got=%b/%b exp=0", m_ovalid, l_ovalid);
    end
  endtask

  task automatic test_backpressure();
    send_frame(4'b1011, 1'b0, 1'b1);
    total++;
    if (m_pout !== 4'b1011 || m_ovalid !== 1'b1 || m_sready !== 1'b1) begin
      bad++; $display("FAIL bp_first got=%b v=%b r=%b exp=1011 v=1 r=1", m_pout, m_ovalid, m_sready);
    end
    send_frame(4'b0110, 1'b0, 1'b0);
    total++;
    if (m_sready !== 1'b0 || l_sready !== 1'b0) begin
      bad++; $display("FAIL bp_stall got=%b/%b exp=0", m_sready, l_sready);
    end
    // serial_valid must be ignored while stalled
    step(1'b1, 1'b1, 1'b0, 1'b1);
    total++;
    if (m_pout !== 4'b1011 || l_pout !== 4'b1101 || m_sready !== 1'b0) begin
      bad++; $display("FAIL bp_hold got=%b/%b r=%b exp=1011/1101 r=0", m_pout, l_pout, m_sready);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (m_pout !== 4'b0110 || l_pout !== 4'b0110 || m_ovalid !== 1'b1 || m_sready !== 1'b1) begin
      bad++; $display("FAIL bp_release got=%b/%b v=%b r=%b exp=0110/0110 v=1 r=1", m_pout, l_pout, m_ovalid, m_sready);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (m_ovalid !== 1'b0) begin
      bad++; $display("FAIL bp_drain got=%b exp=0", m_ovalid);
    end
  endtask

  task automatic test_reset_midword();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (m_ovalid !== 1'b0 || m_pout !== 4'b0000) begin
      bad++; $display("FAIL mid_clear got=%b v=%b exp=0000 v=0", m_pout, m_ovalid);
    end
    send_frame(4'b0110, 1'b1, 1'b0);
    total++;
    if (m_pout !== 4'b0110 || l_pout !== 4'b0110 || m_ovalid !== 1'b1) begin
      bad++; $display("FAIL mid_word got=%b/%b v=%b exp=0110/0110 v=1", m_pout, l_pout, m_ovalid);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_parity();
    send_frame(4'b1101, 1'b1, 1'b1);
    total++;
    if (m_perr !== 1'b0 || m_pout !== 4'b1101) begin
      bad++; $display("FAIL parity_good got=%b w=%b exp=0 w=1101", m_perr, m_pout);
    end
    send_frame(4'b1101, 1'b1, 1'b0);
`ifdef DESER_PARITY_EN
    total++;
    if (m_perr !== 1'b1 || m_pout !== 4'b1101) begin
      bad++; $display("FAIL parity_bad got=%b w=%b exp=1 w=1101", m_perr, m_pout);
    end
`else
    total++;
    if (m_perr !== 1'b0 || l_perr !== 1'b0) begin
      bad++; $display("FAIL parity_tied got=%b/%b exp=0", m_perr, l_perr);
    end
`endif
    step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(99) < 75, 1'($urandom), $urandom_range(99) < 55,
           $urandom_range(99) >= 2);
      total++;
      if (m_sready !== !md_hold || l_sready !== !md_hold) begin
        bad++; $display("FAIL rnd_sready n=%0d got=%b/%b exp=%b", n, m_sready, l_sready, !md_hold);
      end
      total++;
      if (m_ovalid !== md_valid || l_ovalid !== md_valid) begin
        bad++; $display("FAIL rnd_valid n=%0d got=%b/%b exp=%b", n, m_ovalid, l_ovalid, md_valid);
      end
      total++;
      if (m_pout !== md_buf_m || l_pout !== md_buf_l) begin
        bad++; $display("FAIL rnd_word n=%0d got=%b/%b exp=%b/%b", n, m_pout, l_pout, md_buf_m, md_buf_l);
      end
      total++;
      if (m_perr !== md_err || l_perr !== md_err) begin
        bad++; $display("FAIL rnd_perr n=%0d got=%b/%b exp=%b", n, m_perr, l_perr, md_err);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    serial_valid = 1'b0;
    serial_in    = 1'b0;
    out_ready    = 1'b0;
    clear_n      = 1'b0;
    md_valid = 1'b0; md_hold = 1'b0;
    md_buf_m = '0; md_buf_l = '0; md_held_m = '0; md_held_l = '0;
    md_err = 1'b0; md_held_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_bit_order();
    test_backpressure();
    test_reset_midword();
    test_parity();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
